// File: rtl/l1_tag_pkg.sv
// Shared types and constants for the L1 tag array controller.
package l1_tag_pkg;

    localparam int TAG_W = 19;
    localparam int IDX_W = 8;

    localparam logic [TAG_W-1:0] INIT_VALUE = '0;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } tag_state_e;

endpackage

// File: rtl/l1_tag_sram_ctrl.sv
// Sequencer in front of the 1R1W tag SRAM: invalidate sweep, read/write
// arbitration, write-first bypass on same-address collision, 1-cycle read response.
//
// Handshake: a lookup is taken in the cycle rd_valid && rd_ready, an update in
// the cycle wr_valid && wr_ready. Both readies are combinational (low while
// sweeping or while flush_req is high), and an accepted request drives the SRAM
// port in that same cycle. rsp_valid follows an accepted lookup by exactly one
// cycle and cannot be stalled.
module l1_tag_sram_ctrl #(
    parameter int DATA_WIDTH = l1_tag_pkg::TAG_W,
    parameter int ADDR_WIDTH = l1_tag_pkg::IDX_W,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(l1_tag_pkg::INIT_VALUE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    import l1_tag_pkg::*;

    // Counter is one bit wider than the index so the terminal compare never aliases.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    tag_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  flush_done_q, flush_done_d;
    logic [DATA_WIDTH-1:0] byp_q, byp_d;
    logic                  byp_flag_q, byp_flag_d;
    logic                  rd_acc, wr_acc, collide;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        byp_d        = byp_q;
        rd_ready     = 1'b0;
        wr_ready     = 1'b0;
        sram_csb0    = 1'b1;
        sram_addr0   = '0;
        sram_din0    = '0;
        sram_csb1    = 1'b1;
        sram_addr1   = '0;

        case (state_q)
            SWEEP: begin
                sram_csb0  = 1'b0;
                sram_addr0 = cnt_q[ADDR_WIDTH-1:0];
                sram_din0  = INIT_VALUE;
                if (cnt_q == LAST_IDX) begin
                    state_d      = READY;
                    cnt_d        = '0;
                    flush_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            READY: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else begin
                    rd_ready = 1'b1;
                    wr_ready = 1'b1;
                end
            end
            default: state_d = SWEEP;
        endcase

        rd_acc  = rd_valid && rd_ready;
        wr_acc  = wr_valid && wr_ready;
        collide = rd_acc && wr_acc && (rd_addr == wr_addr);

        if (wr_acc) begin
            sram_csb0  = 1'b0;
            sram_addr0 = wr_addr;
            sram_din0  = wr_data;
        end
        // On a collision the read port stays idle; the response comes from the bypass reg.
        if (rd_acc && !collide) begin
            sram_csb1  = 1'b0;
            sram_addr1 = rd_addr;
        end

        rsp_valid_d = rd_acc;
        byp_flag_d  = collide;
        if (collide) begin
            byp_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
            byp_q        <= '0;
            byp_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            flush_done_q <= flush_done_d;
            byp_q        <= byp_d;
            byp_flag_q   <= byp_flag_d;
        end
    end

    assign busy       = (state_q == SWEEP);
    assign flush_done = flush_done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_valid_q ? (byp_flag_q ? byp_q : sram_dout1) : '0;

endmodule

// File: tb/tb_l1_tag_sram_ctrl.sv
// Directed bench for l1_tag_sram_ctrl with a behavioural 256x19 1R1W SRAM
// (inputs registered at posedge, array access at negedge).
module tb_l1_tag_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_addr;
    logic        rsp_valid;
    logic [18:0] rsp_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [18:0] wr_data;
    logic        flush_req;
    logic        busy;
    logic        flush_done;
    logic        sram_csb0;
    logic [7:0]  sram_addr0;
    logic [18:0] sram_din0;
    logic        sram_csb1;
    logic [7:0]  sram_addr1;
    logic [18:0] sram_dout1;

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q[$];

    l1_tag_sram_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .flush_req  (flush_req),
        .busy       (busy),
        .flush_done (flush_done),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [18:0] mem [0:255];
    logic        csb0_r = 1'b1;
    logic        csb1_r = 1'b1;
    logic [7:0]  addr0_r, addr1_r;
    logic [18:0] din0_r;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 19'($urandom);
    end

    always @(posedge clk) begin
        csb0_r  <= sram_csb0;
        addr0_r <= sram_addr0;
        din0_r  <= sram_din0;
        csb1_r  <= sram_csb1;
        addr1_r <= sram_addr1;
    end

    always @(negedge clk) begin
        if (!csb0_r) mem[addr0_r] <= din0_r;
        if (!csb1_r) sram_dout1 <= mem[addr1_r];
    end

    // ---------------- driver tasks ----------------
    // Each task leaves time at 1ns after a rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [7:0] a, input logic [18:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic read_resp(input logic [7:0] a, output logic v, output logic [18:0] d);
        rd_valid = 1'b1;
        rd_addr  = a;
        cyc();
        rd_valid = 1'b0;
        #5;
        v = rsp_valid;
        d = rsp_data;
        cyc();
    endtask

    // Full 256-entry sweep starting with counter 0 in the current cycle.
    task automatic run_sweep(input string tag);
        for (int i = 0; i < 256; i++) begin
            #5;
            checks++;
            if (busy !== 1'b1 || sram_csb0 !== 1'b0 || sram_addr0 !== 8'(i) ||
                sram_din0 !== 19'h0 || rd_ready !== 1'b0 || wr_ready !== 1'b0 || sram_csb1 !== 1'b1) begin
                errors++;
                $display("FAIL %s_sweep_step i=%0d: busy=%b csb0=%b addr0=%h din0=%h rd_rdy=%b wr_rdy=%b csb1=%b; want 1 0 %h 0 0 0 1",
                         tag, i, busy, sram_csb0, sram_addr0, sram_din0, rd_ready, wr_ready, sram_csb1, 8'(i));
            end
            cyc();
        end
        #5;
        checks++;
        if (flush_done !== 1'b1 || busy !== 1'b0 || rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_sweep_end: flush_done=%b busy=%b rd_ready=%b wr_ready=%b; want 1 0 1 1",
                     tag, flush_done, busy, rd_ready, wr_ready);
        end
        cyc();
        #5;
        checks++;
        if (flush_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse_width: flush_done=%b busy=%b; want 0 0", tag, flush_done, busy);
        end
        cyc();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; flush_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) cyc();
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 19'h0 || flush_done !== 1'b0 ||
            rd_ready !== 1'b0 || wr_ready !== 1'b0 || sram_csb1 !== 1'b1 || sram_addr0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: busy=%b rsp_v=%b rsp_d=%h fd=%b rd_rdy=%b wr_rdy=%b csb1=%b addr0=%h; want 1 0 0 0 0 0 1 00",
                     busy, rsp_valid, rsp_data, flush_done, rd_ready, wr_ready, sram_csb1, sram_addr0);
        end
        rst_n = 1'b1;
        run_sweep("init");
    endtask

    task automatic test_write_read();
        wr_valid = 1'b1; wr_addr = 8'h3A; wr_data = 19'h5_1234;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || sram_csb0 !== 1'b0 || sram_addr0 !== 8'h3A || sram_din0 !== 19'h5_1234) begin
            errors++;
            $display("FAIL wr_port_drive: wr_ready=%b csb0=%b addr0=%h din0=%h; want 1 0 3a 51234",
                     wr_ready, sram_csb0, sram_addr0, sram_din0);
        end
        cyc();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 8'h3A;
        #1;
        checks++;
        if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b0 || sram_addr1 !== 8'h3A || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_port_drive: csb0=%b csb1=%b addr1=%h rsp_valid=%b; want 1 0 3a 0",
                     sram_csb0, sram_csb1, sram_addr1, rsp_valid);
        end
        cyc();
        rd_valid = 1'b0;
        #5;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 19'h5_1234) begin
            errors++;
            $display("FAIL wr_then_rd_rsp: rsp_valid=%b rsp_data=%h; want 1 51234", rsp_valid, rsp_data);
        end
        cyc();
        #5;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_one_cycle: rsp_valid=%b; want 0", rsp_valid);
        end
        cyc();
    endtask

    task automatic test_collision();
        logic v;
        logic [18:0] d;
        rd_valid = 1'b1; rd_addr = 8'h10;
        wr_valid = 1'b1; wr_addr = 8'h10; wr_data = 19'h7_FFFF;
        #1;
        checks++;
        if (rd_ready !== 1'b1 || wr_ready !== 1'b1 || sram_csb1 !== 1'b1 || sram_csb0 !== 1'b0 || sram_addr0 !== 8'h10) begin
            errors++;
            $display("FAIL collide_ports: rd_rdy=%b wr_rdy=%b csb1=%b csb0=%b addr0=%h; want 1 1 1 0 10",
                     rd_ready, wr_ready, sram_csb1, sram_csb0, sram_addr0);
        end
        cyc();
        rd_valid = 1'b0; wr_valid = 1'b0;
        #5;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 19'h7_FFFF) begin
            errors++;
            $display("FAIL collide_bypass_rsp: rsp_valid=%b rsp_data=%h; want 1 7ffff", rsp_valid, rsp_data);
        end
        cyc();
        read_resp(8'h10, v, d);
        checks++;
        if (v !== 1'b1 || d !== 19'h7_FFFF) begin
            errors++;
            $display("FAIL collide_later_read: rsp_valid=%b rsp_data=%h; want 1 7ffff", v, d);
        end
    endtask

    task automatic test_parallel();
        logic v;
        logic [18:0] d;
        write_one(8'h20, 19'h0_0AAA);
        rd_valid = 1'b1; rd_addr = 8'h20;
        wr_valid = 1'b1; wr_addr = 8'h21; wr_data = 19'h1_2345;
        #1;
        checks++;
        if (sram_csb0 !== 1'b0 || sram_addr0 !== 8'h21 || sram_din0 !== 19'h1_2345 ||
            sram_csb1 !== 1'b0 || sram_addr1 !== 8'h20) begin
            errors++;
            $display("FAIL parallel_ports: csb0=%b addr0=%h din0=%h csb1=%b addr1=%h; want 0 21 12345 0 20",
                     sram_csb0, sram_addr0, sram_din0, sram_csb1, sram_addr1);
        end
        cyc();
        rd_valid = 1'b0; wr_valid = 1'b0;
        #5;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 19'h0_0AAA) begin
            errors++;
            $display("FAIL parallel_rsp: rsp_valid=%b rsp_data=%h; want 1 00aaa", rsp_valid, rsp_data);
        end
        cyc();
        read_resp(8'h21, v, d);
        checks++;
        if (v !== 1'b1 || d !== 19'h1_2345) begin
            errors++;
            $display("FAIL parallel_later_read: rsp_valid=%b rsp_data=%h; want 1 12345", v, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  addrs [3];
        logic [18:0] vals  [3];
        logic [18:0] exp;
        addrs[0] = 8'h3A; vals[0] = 19'h5_1234;
        addrs[1] = 8'h10; vals[1] = 19'h7_FFFF;
        addrs[2] = 8'h20; vals[2] = 19'h0_0AAA;
        for (int j = 0; j < 3; j++) begin
            rd_valid = 1'b1; rd_addr = addrs[j];
            #5;
            if (j > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: rsp_valid=%b rsp_data=%h; want 1 %h", j - 1, rsp_valid, rsp_data, exp);
                end
            end
            exp_q.push_back(vals[j]);
            cyc();
        end
        rd_valid = 1'b0;
        #5;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
            errors++;
            $display("FAIL b2b_rsp2: rsp_valid=%b rsp_data=%h; want 1 %h", rsp_valid, rsp_data, exp);
        end
        cyc();
        #5;
        checks++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: rsp_valid=%b pending=%0d; want 0 0", rsp_valid, exp_q.size());
        end
        cyc();
    endtask

    task automatic test_flush();
        logic v;
        logic [18:0] d;
        flush_req = 1'b1; rd_valid = 1'b1; rd_addr = 8'h3A;
        #1;
        checks++;
        if (rd_ready !== 1'b0 || wr_ready !== 1'b0 || sram_csb1 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_req: rd_rdy=%b wr_rdy=%b csb1=%b busy=%b; want 0 0 1 0",
                     rd_ready, wr_ready, sram_csb1, busy);
        end
        cyc();
        flush_req = 1'b0; rd_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_read_dropped: rsp_valid=%b; want 0", rsp_valid);
        end
        run_sweep("flush");
        read_resp(8'h3A, v, d);
        checks++;
        if (v !== 1'b1 || d !== 19'h0) begin
            errors++;
            $display("FAIL flush_inval_3a: rsp_valid=%b rsp_data=%h; want 1 00000", v, d);
        end
        read_resp(8'h10, v, d);
        checks++;
        if (v !== 1'b1 || d !== 19'h0) begin
            errors++;
            $display("FAIL flush_inval_10: rsp_valid=%b rsp_data=%h; want 1 00000", v, d);
        end
    endtask

    task automatic test_async_reset();
        rd_valid = 1'b1; rd_addr = 8'h21;
        cyc();
        rd_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pending_rsp: rsp_valid=%b; want 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 19'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_drops_rsp: rsp_valid=%b rsp_data=%h busy=%b; want 0 0 1", rsp_valid, rsp_data, busy);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #5;
            checks++;
            if (busy !== 1'b1 || sram_addr0 !== 8'(i)) begin
                errors++;
                $display("FAIL rst_partial_sweep i=%0d: busy=%b addr0=%h; want 1 %h", i, busy, sram_addr0, 8'(i));
            end
            cyc();
        end
        #1;
        checks++;
        if (sram_addr0 !== 8'd100) begin
            errors++;
            $display("FAIL rst_at_count100: addr0=%h; want 64", sram_addr0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sram_addr0 !== 8'h00 || busy !== 1'b1 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_sweep: addr0=%h busy=%b flush_done=%b; want 00 1 0", sram_addr0, busy, flush_done);
        end
        cyc();
        rst_n = 1'b1;
        run_sweep("restart");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_parallel();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
